// File: rtl/line_sensor_emu_pkg.sv
// ---------------------------------------------------------------------------
// line_sensor_emu_pkg
// Shared types and constants for the line-sensor emulator: sequencer state
// encoding, counter widths, and the noise LFSR seed/tap mask with its step
// function (used only when LINE_SENSOR_EMU_NOISE_EN is defined).
// ---------------------------------------------------------------------------
package line_sensor_emu_pkg;

    localparam int INTEG_W = 21;
    localparam int FRAME_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        INTEG,
        LEAD,
        READOUT,
        EOC
    } state_t;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/line_sensor_emu_if.sv
// ---------------------------------------------------------------------------
// line_sensor_emu_if
// Sensor drive / sensor response bundle.
//   SENSOR_CLK, ST          : driven by the FPGA side (master)
//   EOC, TRIG, VIDEO,
//   INTEG_CNT, FRAME_CNT,
//   OVERRUN                 : driven by the emulator (slave)
// Parameter PIX_W sets the VIDEO width.
// ---------------------------------------------------------------------------
interface line_sensor_emu_if
    import line_sensor_emu_pkg::*;
#(
    parameter int PIX_W = 12
);
    logic               SENSOR_CLK;
    logic               ST;
    logic               EOC;
    logic               TRIG;
    logic [PIX_W-1:0]   VIDEO;
    logic [INTEG_W-1:0] INTEG_CNT;
    logic [FRAME_W-1:0] FRAME_CNT;
    logic               OVERRUN;

    modport master (
        output SENSOR_CLK, ST,
        input  EOC, TRIG, VIDEO, INTEG_CNT, FRAME_CNT, OVERRUN
    );

    modport slave (
        input  SENSOR_CLK, ST,
        output EOC, TRIG, VIDEO, INTEG_CNT, FRAME_CNT, OVERRUN
    );
endinterface

// File: rtl/line_sensor_emu_sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-FF synchroniser followed by a history FF. The level, rise and fall
// outputs are all registered from the same stage so they stay aligned:
// a 0->1 on din shows up on rise three FPGA_CLK edges later, for one cycle.
// Ports:
//   FPGA_CLK  in   clock
//   FPGA_RST  in   synchronous active-high reset
//   din       in   asynchronous input
//   level     out  synchronised level
//   rise      out  one-cycle pulse on 0->1
//   fall      out  one-cycle pulse on 1->0
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic FPGA_CLK,
    input  logic FPGA_RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync_p0;
    logic sync_p1;
    logic lvl_p2;
    logic rise_p2;
    logic fall_p2;

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            lvl_p2  <= 1'b0;
            rise_p2 <= 1'b0;
            fall_p2 <= 1'b0;
        end else begin
            // p0/p1: metastability filter
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // p2: history and edge detect
            lvl_p2  <= sync_p1;
            rise_p2 <= sync_p1 & ~lvl_p2;
            fall_p2 <= ~sync_p1 & lvl_p2;
        end
    end

    assign level = lvl_p2;
    assign rise  = rise_p2;
    assign fall  = fall_p2;
endmodule

// File: rtl/line_sensor_emu.sv
// ---------------------------------------------------------------------------
// line_sensor_emu
// Sensor-side responder for the FPGA sensor drive. Samples SENSOR_CLK and
// ST, measures integration (SENSOR_CLK rises with ST high), then plays out
// PIXELS pixels with a one-cycle TRIG each and closes with an EOC pulse.
// Pixel value is the ramp (index + FRAME_CNT) mod 2^PIX_W.
//
// Build option: define LINE_SENSOR_EMU_NOISE_EN to XOR VIDEO[3:0] with a
// 16-bit Fibonacci LFSR that advances once per emitted pixel.
//
// Ports:
//   FPGA_CLK  in  system clock
//   FPGA_RST  in  synchronous active-high reset
//   bus       line_sensor_emu_if.slave (SENSOR_CLK, ST in; EOC, TRIG,
//             VIDEO, INTEG_CNT, FRAME_CNT, OVERRUN out)
// ---------------------------------------------------------------------------
module line_sensor_emu
    import line_sensor_emu_pkg::*;
#(
    parameter int PIXELS    = 1024,
    parameter int LEAD_CLKS = 3,
    parameter int EOC_CLKS  = 2,
    parameter int PIX_W     = 12
) (
    input  logic             FPGA_CLK,
    input  logic             FPGA_RST,
    line_sensor_emu_if.slave bus
);
    localparam int IDX_W  = $clog2(PIXELS);
    localparam int LEAD_W = $clog2(LEAD_CLKS + 1);
    localparam int EOC_W  = $clog2(EOC_CLKS + 1);

    function automatic logic [INTEG_W-1:0] sat_inc(input logic [INTEG_W-1:0] x);
        return (x == {INTEG_W{1'b1}}) ? x : x + INTEG_W'(1);
    endfunction

    function automatic logic [PIX_W-1:0] ramp_value(input logic [IDX_W-1:0]   idx,
                                                     input logic [FRAME_W-1:0] frame);
        logic [31:0] sum;
        sum = 32'(idx) + 32'(frame);
        return sum[PIX_W-1:0];
    endfunction

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic st_lvl, st_rise, st_fall;

    sync_edge u_sync_sclk (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .din      (bus.SENSOR_CLK),
        .level    (sclk_lvl),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    sync_edge u_sync_st (
        .FPGA_CLK (FPGA_CLK),
        .FPGA_RST (FPGA_RST),
        .din      (bus.ST),
        .level    (st_lvl),
        .rise     (st_rise),
        .fall     (st_fall)
    );

    // Only the SENSOR_CLK rise and ST level drive the sequencer.
    logic unused_sync;
    assign unused_sync = &{1'b0, sclk_lvl, sclk_fall, st_rise, st_fall};

    state_t             state_q, state_nxt;
    logic [INTEG_W-1:0] integ_q;
    logic [INTEG_W-1:0] integ_cnt_q;
    logic [LEAD_W-1:0]  lead_q;
    logic [IDX_W-1:0]   pix_idx_q;
    logic [EOC_W-1:0]   eoc_cnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               trig_q;
    logic               eoc_q;
    logic               overrun_q;
    logic [PIX_W-1:0]   video_q;

    logic               lead_last, pix_last, eoc_last;
    logic               emit, frame_done;
    logic [IDX_W-1:0]   emit_idx;
    logic [PIX_W-1:0]   ramp, pix_val;

    assign lead_last = (lead_q    == LEAD_W'(LEAD_CLKS - 1));
    assign pix_last  = (pix_idx_q == IDX_W'(PIXELS - 1));
    assign eoc_last  = (eoc_cnt_q == EOC_W'(EOC_CLKS - 1));

    // Pixel 0 leaves on the final LEAD rise, before pix_idx_q has been set up.
    assign emit_idx = (state_q == READOUT) ? pix_idx_q : '0;
    assign ramp     = ramp_value(emit_idx, frame_q);

`ifdef LINE_SENSOR_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_adv;

    assign lfsr_adv = lfsr_next(lfsr_q);
    assign pix_val  = ramp ^ PIX_W'(lfsr_adv[3:0]);

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            lfsr_q <= LFSR_SEED;
        end else if (emit) begin
            lfsr_q <= lfsr_adv;
        end
    end
`else
    assign pix_val = ramp;
`endif

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        emit       = 1'b0;
        frame_done = 1'b0;
        if (sclk_rise) begin
            unique case (state_q)
                IDLE:    if (st_lvl) state_nxt = INTEG;
                INTEG:   if (!st_lvl) state_nxt = LEAD;
                LEAD: begin
                    if (lead_last) begin
                        state_nxt = READOUT;
                        emit      = 1'b1;
                    end
                end
                READOUT: begin
                    emit = 1'b1;
                    if (pix_last) state_nxt = EOC;
                end
                EOC: begin
                    if (eoc_last) begin
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            integ_q     <= '0;
            integ_cnt_q <= '0;
            lead_q      <= '0;
            pix_idx_q   <= '0;
            eoc_cnt_q   <= '0;
            frame_q     <= '0;
            trig_q      <= 1'b0;
            eoc_q       <= 1'b0;
            overrun_q   <= 1'b0;
            video_q     <= '0;
        end else begin
            trig_q <= emit;
            if (emit) video_q <= pix_val;

            // EOC comes up the cycle after the last TRIG and drops on the final EOC rise.
            eoc_q <= (state_q == EOC) && !frame_done;

            if (sclk_rise && st_lvl &&
                (state_q == LEAD || state_q == READOUT || state_q == EOC)) begin
                overrun_q <= 1'b1;
            end

            if (sclk_rise) begin
                case (state_q)
                    IDLE: begin
                        if (st_lvl) integ_q <= INTEG_W'(1);
                    end
                    INTEG: begin
                        if (st_lvl) begin
                            integ_q <= sat_inc(integ_q);
                        end else begin
                            integ_cnt_q <= integ_q;
                            lead_q      <= '0;
                        end
                    end
                    LEAD: begin
                        lead_q <= lead_q + LEAD_W'(1);
                        if (lead_last) pix_idx_q <= IDX_W'(1);
                    end
                    READOUT: begin
                        pix_idx_q <= pix_idx_q + IDX_W'(1);
                        if (pix_last) eoc_cnt_q <= '0;
                    end
                    EOC: begin
                        eoc_cnt_q <= eoc_cnt_q + EOC_W'(1);
                        if (eoc_last) frame_q <= frame_q + FRAME_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.EOC       = eoc_q;
    assign bus.TRIG      = trig_q;
    assign bus.VIDEO     = video_q;
    assign bus.INTEG_CNT = integ_cnt_q;
    assign bus.FRAME_CNT = frame_q;
    assign bus.OVERRUN   = overrun_q;
endmodule

// File: tb/tb_line_sensor_emu.sv
// ---------------------------------------------------------------------------
// tb_line_sensor_emu
// Bench for line_sensor_emu with PIXELS=8, LEAD_CLKS=2, EOC_CLKS=2, PIX_W=12
// and a 16-cycle SENSOR_CLK. Expected pixel values are queued when a frame
// is started and checked by a monitor whenever TRIG is high. Define
// LINE_SENSOR_EMU_NOISE_EN for both RTL and bench to cover the noise build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_line_sensor_emu;
    localparam int PIXELS    = 8;
    localparam int LEAD_CLKS = 2;
    localparam int EOC_CLKS  = 2;
    localparam int PIX_W     = 12;
    localparam int SCLK_PER  = 16;
    localparam int EOC_HIGH  = EOC_CLKS * SCLK_PER - 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic st   = 1'b0;

    line_sensor_emu_if #(.PIX_W(PIX_W)) bus ();
    assign bus.SENSOR_CLK = sclk;
    assign bus.ST         = st;

    line_sensor_emu #(
        .PIXELS    (PIXELS),
        .LEAD_CLKS (LEAD_CLKS),
        .EOC_CLKS  (EOC_CLKS),
        .PIX_W     (PIX_W)
    ) dut (
        .FPGA_CLK (clk),
        .FPGA_RST (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #80 sclk = ~sclk;
    end

    int tests = 0;
    int failed = 0;
    int trig_cnt = 0;
    int eoc_cyc = 0;
    int exp_frame = 0;
    logic [15:0] exp_lfsr = 16'hACE1;
    logic [PIX_W-1:0] sb_q[$];
    logic trig_prev = 1'b0;
    logic eoc_prev = 1'b0;

`ifdef LINE_SENSOR_EMU_NOISE_EN
    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction
`endif

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [PIX_W-1:0] ev;
        if (!rst) begin
            if (bus.TRIG === 1'b1) begin
                trig_cnt++;
                tests++;
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL video_unexpected got %0d want no pixel", bus.VIDEO);
                end else begin
                    ev = sb_q.pop_front();
                    if (bus.VIDEO !== ev) begin
                        failed++;
                        $display("FAIL video got %0d want %0d", bus.VIDEO, ev);
                    end
                end
                tests++;
                if (trig_prev !== 1'b0) begin
                    failed++;
                    $display("FAIL trig_width got prev=%b want 0", trig_prev);
                end
            end
            if (bus.EOC === 1'b1) eoc_cyc++;
            if (bus.EOC === 1'b1 && eoc_prev === 1'b0) begin
                tests++;
                if (!(trig_prev === 1'b1 && bus.TRIG === 1'b0)) begin
                    failed++;
                    $display("FAIL eoc_gap got trig_prev=%b trig=%b want 1,0", trig_prev, bus.TRIG);
                end
            end
        end
        trig_prev = bus.TRIG;
        eoc_prev  = bus.EOC;
    end

    // mode: 0 normal, 1 raise ST during pixel 3, 2 reset after pixel 4
    task automatic run_frame(input int st_rises, input bit sat, input int mode,
                             output bit done, output int lead_rises,
                             output int trigs, output int eocs);
        logic [31:0] t;
        logic [PIX_W-1:0] v;
        int base_trig, base_eoc, rises, ovr_phase, ovr_falls;
        logic prev_s;
        for (int i = 0; i < PIXELS; i++) begin
            t = 32'(i + exp_frame);
            v = t[PIX_W-1:0];
`ifdef LINE_SENSOR_EMU_NOISE_EN
            exp_lfsr = lfsr_model(exp_lfsr);
            v[3:0] = v[3:0] ^ exp_lfsr[3:0];
`endif
            sb_q.push_back(v);
        end
        base_trig = trig_cnt;
        base_eoc  = eoc_cyc;
        @(negedge sclk);
        st = 1'b1;
        for (int r = 0; r < st_rises; r++) begin
            @(negedge sclk);
            if (sat && r == 0) begin
                // Jump the integration counter close to the top.
                force dut.integ_q = 21'h1FFFFD;
                @(posedge clk);
                #1;
                release dut.integ_q;
            end
        end
        st = 1'b0;
        done = 1'b0;
        lead_rises = -1;
        rises = 0;
        ovr_phase = 0;
        ovr_falls = 0;
        prev_s = sclk;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk);
            #2;
            if (sclk && !prev_s) rises++;
            if (mode == 1) begin
                if (ovr_phase == 0 && trig_cnt == base_trig + 4) ovr_phase = 1;
                else if (ovr_phase == 1 && !sclk && prev_s) begin
                    st = 1'b1;
                    ovr_phase = 2;
                end else if (ovr_phase == 2 && !sclk && prev_s) begin
                    ovr_falls++;
                    if (ovr_falls == 2) begin
                        st = 1'b0;
                        ovr_phase = 3;
                    end
                end
            end
            prev_s = sclk;
            if (lead_rises < 0 && trig_cnt != base_trig) lead_rises = rises;
            if (mode == 2 && trig_cnt == base_trig + 5) begin
                rst = 1'b1;
                @(posedge clk);
                #2;
                trigs = trig_cnt - base_trig;
                eocs  = eoc_cyc - base_eoc;
                return;
            end
            if (bus.FRAME_CNT == 16'(exp_frame + 1)) done = 1'b1;
        end
        trigs = trig_cnt - base_trig;
        eocs  = eoc_cyc - base_eoc;
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL frame_timeout got FRAME_CNT=%0d want %0d", bus.FRAME_CNT, exp_frame + 1);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({bus.EOC, bus.TRIG, bus.OVERRUN} !== 3'b000) begin
            failed++;
            $display("FAIL reset_flags got %b want 000", {bus.EOC, bus.TRIG, bus.OVERRUN});
        end
        tests++;
        if (bus.VIDEO !== '0) begin
            failed++;
            $display("FAIL reset_video got %0d want 0", bus.VIDEO);
        end
        tests++;
        if (bus.INTEG_CNT !== '0) begin
            failed++;
            $display("FAIL reset_integ got %0d want 0", bus.INTEG_CNT);
        end
        tests++;
        if (bus.FRAME_CNT !== '0) begin
            failed++;
            $display("FAIL reset_frame got %0d want 0", bus.FRAME_CNT);
        end
    endtask

    task automatic test_single_frame();
        bit done;
        int lr, tr, ec;
        run_frame(5, 1'b0, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.INTEG_CNT !== 21'd5) begin
            failed++;
            $display("FAIL single_integ got %0d want 5", bus.INTEG_CNT);
        end
        // Rises counted from the one that samples ST low up to pixel 0.
        tests++;
        if (lr != LEAD_CLKS + 1) begin
            failed++;
            $display("FAIL single_lead got %0d want %0d", lr, LEAD_CLKS + 1);
        end
        tests++;
        if (tr != PIXELS) begin
            failed++;
            $display("FAIL single_trigs got %0d want %0d", tr, PIXELS);
        end
        tests++;
        if (ec != EOC_HIGH) begin
            failed++;
            $display("FAIL single_eoc_len got %0d want %0d", ec, EOC_HIGH);
        end
        tests++;
        if (bus.FRAME_CNT !== 16'd1) begin
            failed++;
            $display("FAIL single_frame got %0d want 1", bus.FRAME_CNT);
        end
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL single_pending got %0d want 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        int lr, tr, ec;
        run_frame(3, 1'b0, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.INTEG_CNT !== 21'd3 || tr != PIXELS) begin
            failed++;
            $display("FAIL b2b_first got integ=%0d trigs=%0d want 3,%0d", bus.INTEG_CNT, tr, PIXELS);
        end
        run_frame(1, 1'b0, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.INTEG_CNT !== 21'd1 || tr != PIXELS) begin
            failed++;
            $display("FAIL b2b_second got integ=%0d trigs=%0d want 1,%0d", bus.INTEG_CNT, tr, PIXELS);
        end
        tests++;
        if (bus.FRAME_CNT !== 16'(exp_frame) || bus.OVERRUN !== 1'b0) begin
            failed++;
            $display("FAIL b2b_state got frame=%0d ovr=%b want %0d,0", bus.FRAME_CNT, bus.OVERRUN, exp_frame);
        end
    endtask

    task automatic test_overrun();
        bit done;
        int lr, tr, ec, t0;
        run_frame(4, 1'b0, 1, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.OVERRUN !== 1'b1) begin
            failed++;
            $display("FAIL ovr_flag got %b want 1", bus.OVERRUN);
        end
        tests++;
        if (tr != PIXELS || ec != EOC_HIGH) begin
            failed++;
            $display("FAIL ovr_frame got trigs=%0d eoc=%0d want %0d,%0d", tr, ec, PIXELS, EOC_HIGH);
        end
        t0 = trig_cnt;
        repeat (6 * SCLK_PER) @(posedge clk);
        #2;
        tests++;
        if (trig_cnt != t0 || bus.FRAME_CNT !== 16'(exp_frame) || bus.INTEG_CNT !== 21'd4) begin
            failed++;
            $display("FAIL ovr_no_restart got trigs=%0d frame=%0d integ=%0d want 0,%0d,4",
                     trig_cnt - t0, bus.FRAME_CNT, bus.INTEG_CNT, exp_frame);
        end
        run_frame(2, 1'b0, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.OVERRUN !== 1'b1) begin
            failed++;
            $display("FAIL ovr_sticky got %b want 1", bus.OVERRUN);
        end
    endtask

    task automatic test_reset_midframe();
        bit done;
        int lr, tr, ec, e0;
        run_frame(3, 1'b0, 2, done, lr, tr, ec);
        test_reset();
        tests++;
        if (bus.OVERRUN !== 1'b0 || sb_q.size() != PIXELS - 5) begin
            failed++;
            $display("FAIL rst_mid got ovr=%b pending=%0d want 0,%0d", bus.OVERRUN, sb_q.size(), PIXELS - 5);
        end
        rst = 1'b0;
        sb_q.delete();
        exp_frame = 0;
        exp_lfsr = 16'hACE1;
        e0 = eoc_cyc;
        repeat (6 * SCLK_PER) @(posedge clk);
        #2;
        tests++;
        if (eoc_cyc != e0 || bus.FRAME_CNT !== 16'd0) begin
            failed++;
            $display("FAIL rst_abort got eoc=%0d frame=%0d want 0,0", eoc_cyc - e0, bus.FRAME_CNT);
        end
        run_frame(2, 1'b0, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.FRAME_CNT !== 16'd1 || bus.INTEG_CNT !== 21'd2 || tr != PIXELS) begin
            failed++;
            $display("FAIL rst_clean got frame=%0d integ=%0d trigs=%0d want 1,2,%0d",
                     bus.FRAME_CNT, bus.INTEG_CNT, tr, PIXELS);
        end
    endtask

    task automatic test_saturation();
        bit done;
        int lr, tr, ec;
        run_frame(6, 1'b1, 0, done, lr, tr, ec);
        exp_frame++;
        tests++;
        if (bus.INTEG_CNT !== 21'd2097151) begin
            failed++;
            $display("FAIL integ_sat got %0d want 2097151", bus.INTEG_CNT);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #2;
        test_reset();
        rst = 1'b0;
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule
